usb_ctrl_regfile: RTL and testbench

Parametrised control-register file fed by the USB byte-stream packet parser. It decodes CTRL/ADDR/DATA packets into NUM_REGS registers of configurable byte length, commits writes atomically only on a correctly sized packet, and supports register read-back through a ready/valid byte port. Its outputs drive the SDI/CSI interface control fields; it replaces the fixed two-register decoder.

---
 rtl/usb_ctrl_pkg.sv | 25 ++
 rtl/usb_byte_serializer.sv | 41 ++++
 rtl/usb_ctrl_regfile.sv | 140 ++++++++++++++
 tb/tb_usb_ctrl_regfile.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_ctrl_pkg.sv
// Shared types for the USB control-register file: parser states, error codes,
// and a lookup into the packed per-register length table.
package usb_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_CTRL,
      ST_ADDR,
      ST_DATA,
      ST_READ,
      ST_DROP
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_BAD_ADDR = 2'd1;
   localparam logic [1:0] ERR_SHORT    = 2'd2;
   localparam logic [1:0] ERR_LONG     = 2'd3;

   // Length tables are zero-extended to this width so one function serves any NUM_REGS.
   localparam int LEN_TBL_W = 256;

   function automatic logic [3:0] reg_len(input logic [LEN_TBL_W-1:0] tbl, input int idx);
      return tbl[idx*4 +: 4];
   endfunction

endpackage

// File: rtl/usb_byte_serializer.sv
// Emits the low `len` bytes of a loaded word MSB-first over a ready/valid byte port.
module usb_byte_serializer #(
   parameter int MAX_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [MAX_BYTES*8-1:0] load_word,
   input  logic [3:0]             load_len,
   output logic [7:0]             rd_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic                   done
);

   localparam int RW = MAX_BYTES*8;

   logic [RW-1:0] word;
   logic [3:0]    rem;

   // The word is left-aligned on load so the next byte out is always the top byte.
   assign rd_data = word[RW-1 -: 8];
   assign done    = rd_valid & rd_ready & (rem == 4'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         word     <= '0;
         rem      <= '0;
         rd_valid <= 1'b0;
      end else if (load) begin
         word     <= load_word << (8 * (MAX_BYTES - int'(load_len)));
         rem      <= load_len;
         rd_valid <= (load_len != 4'd0);
      end else if (rd_valid && rd_ready) begin
         word <= word << 8;
         rem  <= rem - 4'd1;
         if (rem == 4'd1) rd_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/usb_ctrl_regfile.sv
// Packet-driven control register file: CTRL/ADDR/DATA byte packets write registers
// atomically on exact-length packets; read packets stream a register snapshot back.
module usb_ctrl_regfile
   import usb_ctrl_pkg::*;
#(
   parameter int                    NUM_REGS    = 4,
   parameter int                    MAX_BYTES   = 4,
   parameter logic [7:0]            BASE_ADDR   = 8'h08,
   parameter int                    ADDR_STRIDE = 2,
   // Listed reg3..reg0: reg1 is the 3-byte register.
   parameter logic [NUM_REGS*4-1:0] REG_LEN     = {4'd2, 4'd2, 4'd3, 4'd2}
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            frame,
   input  logic [7:0]                      d,
   input  logic                            d_valid,
   output logic                            d_ready,
   output logic [NUM_REGS*MAX_BYTES*8-1:0] q,
   output logic [NUM_REGS-1:0]             wr_stb,
   output logic [7:0]                      rd_data,
   output logic                            rd_valid,
   input  logic                            rd_ready,
   output logic                            err,
   output logic [1:0]                      err_code
);

   localparam int RW = MAX_BYTES*8;
   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [LEN_TBL_W-1:0] LEN_TBL = LEN_TBL_W'(REG_LEN);

   state_t                     state, state_nx;
   logic                       rd_mode;
   logic [IW-1:0]              idx, hit_idx;
   logic [3:0]                 cnt, cur_len, hit_len;
   logic [RW-1:0]              shadow;
   logic [NUM_REGS-1:0][RW-1:0] regs;
   logic                       acc, hit, commit, ser_load, ser_done, err_nx;
   logic [1:0]                 code_nx;

   assign d_ready = (state != ST_READ);
   assign acc     = frame & d_valid & d_ready;
   assign q       = regs;
   assign cur_len = reg_len(LEN_TBL, int'(idx));
   assign hit_len = reg_len(LEN_TBL, int'(hit_idx));

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (d == 8'(int'(BASE_ADDR) + i*ADDR_STRIDE)) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   always_comb begin
      state_nx = state;
      ser_load = 1'b0;
      commit   = 1'b0;
      err_nx   = 1'b0;
      code_nx  = ERR_NONE;
      case (state)
         ST_CTRL: if (acc) state_nx = ST_ADDR;
         ST_ADDR: begin
            if (!frame) begin
               err_nx = 1'b1; code_nx = ERR_SHORT; state_nx = ST_CTRL;
            end else if (d_valid) begin
               if (!hit) begin
                  err_nx = 1'b1; code_nx = ERR_BAD_ADDR; state_nx = ST_DROP;
               end else if (rd_mode) begin
                  ser_load = 1'b1; state_nx = ST_READ;
               end else begin
                  state_nx = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (!frame) begin
               if (cnt == cur_len) commit = 1'b1;
               else begin err_nx = 1'b1; code_nx = ERR_SHORT; end
               state_nx = ST_CTRL;
            end else if (d_valid && cnt == cur_len) begin
               err_nx = 1'b1; code_nx = ERR_LONG; state_nx = ST_DROP;
            end
         end
         ST_READ: if (ser_done) state_nx = ST_DROP;
         ST_DROP: if (!frame) state_nx = ST_CTRL;
         default: state_nx = ST_CTRL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_CTRL;
         rd_mode  <= 1'b0;
         idx      <= '0;
         cnt      <= '0;
         shadow   <= '0;
         regs     <= '0;
         wr_stb   <= '0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         state  <= state_nx;
         wr_stb <= '0;
         err    <= err_nx;
         if (err_nx) err_code <= code_nx;
         if (state == ST_CTRL && acc) rd_mode <= d[0];
         if (state == ST_ADDR && acc && hit) begin
            idx    <= hit_idx;
            cnt    <= '0;
            shadow <= '0;
         end
         // Shifting in from the bottom leaves the first byte at bits [8L-1:8L-8].
         if (state == ST_DATA && acc && cnt != cur_len) begin
            shadow <= (shadow << 8) | RW'(d);
            cnt    <= cnt + 4'd1;
         end
         if (commit) begin
            regs[idx] <= shadow;
            wr_stb    <= NUM_REGS'(1) << idx;
         end
      end
   end

   usb_byte_serializer #(.MAX_BYTES(MAX_BYTES)) u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (ser_load),
      .load_word (regs[hit_idx]),
      .load_len  (hit_len),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .done      (ser_done)
   );

endmodule

// File: tb/tb_usb_ctrl_regfile.sv
// Randomised and directed packet bench for usb_ctrl_regfile against a packet-level model.
module tb_usb_ctrl_regfile;

   localparam int NR = 4;
   localparam int MB = 4;
   localparam int QW = NR*MB*8;

   logic          clk = 1'b0, rst = 1'b1, frame = 1'b0, d_valid = 1'b0, rd_ready = 1'b1;
   logic [7:0]    d = 8'h00;
   logic          d_ready, rd_valid, err;
   logic [QW-1:0] q;
   logic [NR-1:0] wr_stb;
   logic [7:0]    rd_data;
   logic [1:0]    err_code;

   usb_ctrl_regfile dut (
      .clk(clk), .rst(rst), .frame(frame), .d(d), .d_valid(d_valid), .d_ready(d_ready),
      .q(q), .wr_stb(wr_stb), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   int len_m [NR] = '{2, 3, 2, 2};
   logic [NR-1:0][MB*8-1:0] regs_m = '0;
   logic [1:0]    code_m = 2'd0;
   logic [7:0]    pkt[$];
   bit            rdy_pat[$];
   logic [7:0]    rdq[$];
   logic [1:0]    errq[$];
   logic [NR-1:0] stbq[$];
   int            dr_bad = 0;

   int            exp_nerr, exp_rdn, obs_nerr, obs_nstb, obs_rdn, obs_drbad;
   logic [NR-1:0] exp_stb, obs_stb;
   logic [63:0]   exp_rdw, obs_rdw;
   bit            timed_out;

   always @(negedge clk) begin
      if (err) errq.push_back(err_code);
      if (wr_stb != '0) stbq.push_back(wr_stb);
      if (rd_valid && rd_ready) rdq.push_back(rd_data);
      if (rd_valid && d_ready) dr_bad++;
   end

   // Packet-level reference: outcome decided from packet length and address only.
   task automatic model_pkt();
      int ri = -1, n;
      logic [63:0] val;
      exp_nerr = 0; exp_stb = '0; exp_rdn = 0; exp_rdw = '0;
      if (pkt.size() == 0) return;
      if (pkt.size() == 1) begin exp_nerr = 1; code_m = 2'd2; return; end
      for (int i = 0; i < NR; i++) if (pkt[1] == 8'(8'h08 + 2*i)) ri = i;
      if (ri < 0) begin exp_nerr = 1; code_m = 2'd1; return; end
      if (pkt[0][0]) begin
         exp_rdn = len_m[ri];
         exp_rdw = 64'(regs_m[ri]);
         return;
      end
      n = pkt.size() - 2;
      if (n > len_m[ri]) begin exp_nerr = 1; code_m = 2'd3; end
      else if (n < len_m[ri]) begin exp_nerr = 1; code_m = 2'd2; end
      else begin
         val = '0;
         for (int k = 0; k < n; k++) val = (val << 8) | 64'(pkt[2+k]);
         regs_m[ri] = 32'(val);
         exp_stb = NR'(1) << ri;
      end
   endtask

   task automatic run_pkt(input bit gaps);
      int e0 = errq.size(), s0 = stbq.size(), r0 = rdq.size(), d0 = dr_bad, n = 0;
      model_pkt();
      frame = 1'b1;
      foreach (pkt[i]) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin
            d_valid = 1'b0; d = 8'($urandom); @(posedge clk); #1;
         end
         d = pkt[i]; d_valid = 1'b1; @(posedge clk); #1;
      end
      d_valid = 1'b0;
      while (rdq.size() - r0 < exp_rdn && n < 200) begin
         rd_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'($urandom);
         d_valid = 1'($urandom); d = 8'($urandom);
         @(posedge clk); #1; n++;
      end
      timed_out = (n >= 200);
      rd_ready = 1'b1; d_valid = 1'b0; @(posedge clk); #1;
      frame = 1'b0;
      repeat (3) begin d_valid = 1'($urandom); d = 8'($urandom); @(posedge clk); #1; end
      d_valid = 1'b0;
      obs_nerr = errq.size() - e0;
      obs_nstb = stbq.size() - s0;
      obs_stb = '0;
      for (int k = s0; k < stbq.size(); k++) obs_stb |= stbq[k];
      obs_rdn = rdq.size() - r0;
      obs_rdw = '0;
      for (int k = r0; k < rdq.size(); k++) obs_rdw = (obs_rdw << 8) | 64'(rdq[k]);
      obs_drbad = dr_bad - d0;
   endtask

   task automatic test_reset();
      vectors++; if (q !== '0) begin miscompares++; $display("FAIL reset_q got %h exp 0", q); end
      vectors++; if (wr_stb !== '0) begin miscompares++; $display("FAIL reset_wr_stb got %b exp 0", wr_stb); end
      vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
      vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", err); end
      vectors++; if (err_code !== 2'd0) begin miscompares++; $display("FAIL reset_err_code got %0d exp 0", err_code); end
      vectors++; if (d_ready !== 1'b1) begin miscompares++; $display("FAIL reset_d_ready got %b exp 1", d_ready); end
   endtask

   task automatic test_write_paths();
      for (int p = 0; p < 7; p++) begin
         case (p)
            0: pkt = '{8'h00, 8'h08, 8'h92, 8'h08};
            1: pkt = '{8'h00, 8'h0A, 8'h03, 8'h06, 8'h00};
            2: pkt = '{8'h00, 8'h0A, 8'h02, 8'h00};
            3: pkt = '{8'h00, 8'h08, 8'h11, 8'h22, 8'h33};
            4: pkt = '{8'h00, 8'h0C, 8'hAA, 8'hBB};
            5: pkt = '{8'h00, 8'h09, 8'h77, 8'h88};
            default: pkt = '{8'h00, 8'h10, 8'h77, 8'h88};
         endcase
         run_pkt(1'b0);
         vectors++; if (obs_nerr != exp_nerr) begin miscompares++; $display("FAIL wr%0d err_pulses got %0d exp %0d", p, obs_nerr, exp_nerr); end
         vectors++; if (err_code !== code_m) begin miscompares++; $display("FAIL wr%0d err_code got %0d exp %0d", p, err_code, code_m); end
         vectors++; if (obs_nstb != int'(exp_stb != '0)) begin miscompares++; $display("FAIL wr%0d stb_cycles got %0d exp %0d", p, obs_nstb, int'(exp_stb != '0)); end
         vectors++; if (obs_stb !== exp_stb) begin miscompares++; $display("FAIL wr%0d wr_stb got %b exp %b", p, obs_stb, exp_stb); end
         vectors++; if (q !== regs_m) begin miscompares++; $display("FAIL wr%0d q got %h exp %h", p, q, regs_m); end
      end
   endtask

   task automatic test_read();
      pkt = '{8'h01, 8'h0A};
      rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1};
      run_pkt(1'b0);
      vectors++; if (timed_out) begin miscompares++; $display("FAIL rd_timeout got %0d bytes exp %0d", obs_rdn, exp_rdn); end
      vectors++; if (obs_rdn != 3) begin miscompares++; $display("FAIL rd_count got %0d exp 3", obs_rdn); end
      vectors++; if (obs_rdw !== 64'h030600) begin miscompares++; $display("FAIL rd_bytes got %h exp 030600", obs_rdw); end
      vectors++; if (obs_drbad != 0) begin miscompares++; $display("FAIL rd_d_ready got %0d high cycles exp 0", obs_drbad); end
      vectors++; if (obs_nerr != 0) begin miscompares++; $display("FAIL rd_err got %0d exp 0", obs_nerr); end
   endtask

   task automatic test_reset_mid();
      int e0 = errq.size(), s0 = stbq.size();
      frame = 1'b1; d_valid = 1'b1;
      d = 8'h00; @(posedge clk); #1;
      d = 8'h08; @(posedge clk); #1;
      d = 8'h55; @(posedge clk); #1;
      d_valid = 1'b0; rst = 1'b1; @(posedge clk); #1;
      rst = 1'b0; frame = 1'b0;
      regs_m = '0; code_m = 2'd0;
      test_reset();
      repeat (3) @(posedge clk); #1;
      vectors++; if (errq.size() != e0 || stbq.size() != s0) begin
         miscompares++; $display("FAIL rst_mid_quiet got err=%0d stb=%0d exp 0 0", errq.size()-e0, stbq.size()-s0); end
      pkt = '{8'h00, 8'h08, 8'h55, 8'h66};
      run_pkt(1'b1);
      vectors++; if (q !== QW'(32'h5566)) begin miscompares++; $display("FAIL rst_mid_write q got %h exp 5566", q); end
      vectors++; if (obs_stb !== 4'b0001 || obs_nstb != 1) begin miscompares++; $display("FAIL rst_mid_stb got %b x%0d exp 0001 x1", obs_stb, obs_nstb); end
   endtask

   task automatic test_random();
      logic [7:0] a;
      int ri, kind, n;
      for (int p = 0; p < 40; p++) begin
         ri = $urandom_range(0, NR-1);
         a = 8'(8'h08 + 2*ri);
         kind = $urandom_range(0, 9);
         pkt.delete();
         if (kind == 0) begin
            pkt.push_back(8'($urandom));
         end else if (kind == 1) begin
            do a = 8'($urandom); while (a inside {8'h08, 8'h0A, 8'h0C, 8'h0E});
            pkt.push_back({7'($urandom), 1'($urandom)}); pkt.push_back(a);
         end else if (kind < 5) begin
            pkt.push_back({7'($urandom), 1'b1}); pkt.push_back(a);
         end else begin
            pkt.push_back({7'($urandom), 1'b0}); pkt.push_back(a);
            n = (kind < 8) ? len_m[ri] : $urandom_range(0, len_m[ri] + 1);
            repeat (n) pkt.push_back(8'($urandom));
         end
         run_pkt(1'b1);
         vectors++; if (timed_out || obs_rdn != exp_rdn || obs_rdw !== exp_rdw) begin
            miscompares++; $display("FAIL rnd%0d read got %0d:%h exp %0d:%h", p, obs_rdn, obs_rdw, exp_rdn, exp_rdw); end
         vectors++; if (obs_nerr != exp_nerr) begin miscompares++; $display("FAIL rnd%0d err_pulses got %0d exp %0d", p, obs_nerr, exp_nerr); end
         vectors++; if (err_code !== code_m) begin miscompares++; $display("FAIL rnd%0d err_code got %0d exp %0d", p, err_code, code_m); end
         vectors++; if (obs_stb !== exp_stb || obs_nstb != int'(exp_stb != '0)) begin
            miscompares++; $display("FAIL rnd%0d wr_stb got %b x%0d exp %b", p, obs_stb, obs_nstb, exp_stb); end
         vectors++; if (q !== regs_m) begin miscompares++; $display("FAIL rnd%0d q got %h exp %h", p, q, regs_m); end
         vectors++; if (obs_drbad != 0) begin miscompares++; $display("FAIL rnd%0d d_ready_in_read got %0d exp 0", p, obs_drbad); end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_write_paths();
      test_read();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
